data_memory_ctrl: RTL and testbench

//  Byte-addressed MIPS data memory with a valid/ready request port and a registered response.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/data_memory_ctrl_if.sv | 29 ++
 rtl/dmem_lane_align.sv | 52 +++++
 rtl/data_memory_ctrl.sv | 154 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access size codes,
// FSM state constants and the default data-segment base address.
package dmem_pkg;

    // Access size encodings on req_size (2'b11 is handled as a word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Controller FSM states
    typedef logic [1:0] dmem_state_t;
    localparam dmem_state_t IDLE = 2'd0;
    localparam dmem_state_t WAIT = 2'd1;
    localparam dmem_state_t RESP = 2'd2;

    // MIPS data segment start
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h10010000;

    // True when the low offset bits are not a multiple of the access size
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF) begin
            bad = lane[0];
        end else if (size != SZ_BYTE) begin
            bad = (lane != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the data memory controller.
// master = load-store unit side, slave = memory controller side.
interface data_memory_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for a 32-bit little-endian word.
// Store side: byte enables plus write data replicated onto every lane.
// Load side: lane extraction with sign or zero extension.
// Misaligned low bits are simply ignored here (forced alignment).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Store path: enable only the addressed lanes, replicate data so any lane lines up
    always_comb begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        case (size)
            SZ_BYTE: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be          = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
            end
        endcase
    end

    // Load path: pick the lane, then extend to 32 bits
    always_comb begin
        sel_byte = rword[{lane, 3'b000} +: 8];
        sel_half = lane[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: rdata = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
            SZ_HALF: rdata = {{16{~is_unsigned & sel_half[15]}}, sel_half};
            default: rdata = rword;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed MIPS data memory with a valid/ready request port, a
// programmable read latency and a registered one-cycle response pulse.
// Build option: DMEM_MISALIGN_CHECK_EN turns misaligned half/word accesses
// into faults; without it the low offset bits are ignored for the size.
// DATA_WIDTH must be 32; MEMORY_DEPTH a power of two (>= 2).
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           MEMORY_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(DMEM_BASE_ADDR),
    parameter int unsigned           READ_LATENCY = 1
) (
    input logic               clk,
    input logic               reset,
    data_memory_ctrl_if.slave bus
);

    localparam int unsigned IDX_W     = $clog2(MEMORY_DEPTH);
    localparam int unsigned LANES     = DATA_WIDTH / 8;
    localparam logic [1:0]  WAIT_LAST = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    logic [DATA_WIDTH-1:0] ram [MEMORY_DEPTH];

    dmem_state_t           state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  run_q;
    logic [DATA_WIDTH-1:0] pend_rdata_q;
    logic                  pend_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [IDX_W-1:0]      ram_idx;
    logic                  in_range;
    logic                  misalign;
    logic                  fault;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] st_data;
    logic [LANES-1:0]      st_be;
    logic [LANES-1:0]      wr_be;
    logic [DATA_WIDTH-1:0] acc_rdata;
    logic                  acc_err;
    logic                  load_rsp;

    // run_q keeps req_ready low until the first clock after reset release
    assign bus.req_ready = run_q && (state_q == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    assign offset   = bus.req_addr - BASE_ADDR;
    assign word_idx = offset[ADDR_WIDTH-1:2];
    assign ram_idx  = word_idx[IDX_W-1:0];
    assign in_range = word_idx < (ADDR_WIDTH - 2)'(MEMORY_DEPTH);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = is_misaligned(bus.req_size, offset[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign fault   = !in_range || misalign;
    assign rd_word = ram[ram_idx];

    dmem_lane_align u_lane_align (
        .size        (bus.req_size),
        .lane        (offset[1:0]),
        .is_unsigned (bus.req_unsigned),
        .wdata       (bus.req_wdata),
        .rword       (rd_word),
        .be          (st_be),
        .wdata_lanes (st_data),
        .rdata       (ld_data)
    );

    // Stores commit on the acceptance edge; faults suppress the write
    assign wr_be = (accept && bus.req_write && !fault) ? st_be : '0;

    // Response computed from the live request at acceptance, so later input changes are moot
    assign acc_rdata = (bus.req_write || fault) ? '0 : ld_data;
    assign acc_err   = fault;

    // Next-state logic: stores and single-cycle loads skip WAIT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.req_write || (READ_LATENCY <= 1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 2'd0;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response registers load only on entry to RESP and otherwise hold
    assign load_rsp = (state_d == RESP) && (state_q != RESP);

    // FSM, latency counter, pending result and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            run_q        <= 1'b0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            if (accept) begin
                pend_rdata_q <= acc_rdata;
                pend_err_q   <= acc_err;
            end
            if (load_rsp) begin
                rsp_rdata_q <= (state_q == IDLE) ? acc_rdata : pend_rdata_q;
                rsp_err_q   <= (state_q == IDLE) ? acc_err : pend_err_q;
            end
        end
    end

    // Byte-enabled RAM write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_be[i]) begin
                ram[ram_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed scenarios followed by
// random loads/stores compared against a byte-array reference model.
module tb_data_memory_ctrl;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h10010000;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    // Reference memory: plain little-endian byte array
    logic [7:0] bytes_m [4*DEPTH];

    data_memory_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_memory_ctrl #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .MEMORY_DEPTH (DEPTH),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural access model working on byte addresses and integer arithmetic
    function automatic void model_access(input bit wr, input logic [1:0] sz, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int unsigned off;
        int unsigned nb;
        int unsigned start;
        longint      val;
        off = addr - BASE;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        rd  = 32'h0;
        err = 1'b0;
        if (off >= 4 * DEPTH) begin
            err = 1'b1;
            return;
        end
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((off % nb) != 0) begin
            err = 1'b1;
            return;
        end
`endif
        start = off - (off % nb);
        if (wr) begin
            for (int j = 0; j < int'(nb); j++) begin
                bytes_m[start + j] = 8'((wd >> (8 * j)) & 32'hFF);
            end
        end else begin
            val = 0;
            for (int j = 0; j < int'(nb); j++) begin
                val = val + (longint'(bytes_m[start + j]) << (8 * j));
            end
            if (!uns && val >= (64'sd1 << (8 * nb - 1))) begin
                val = val - (64'sd1 << (8 * nb));
            end
            rd = val[31:0];
        end
    endfunction

    // One complete transaction; called and returns at a falling edge
    task automatic do_access(input string tag, input bit wr, input logic [1:0] sz,
                             input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          waitc;
        int          lat;
        model_access(wr, sz, uns, addr, wd, exp_rd, exp_err);
        waitc = 0;
        while (!bus.req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check_val({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(negedge clk);
        // Scramble the request fields; the captured access must be unaffected
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        lat = 1;
        while (!bus.rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), wr ? 32'd1 : 32'(LAT));
        check_val({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
        check_val({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(negedge clk);
        check_val({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          acc;
        int          pulses;
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 4 * int'(DEPTH); i++) bytes_m[i] = 8'h00;
        reset            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_rdata", bus.rsp_rdata, 32'h0);
        check_val("rst_err", 32'(bus.rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Clear the words the bench touches (RAM has no reset)
        for (int w = 0; w < 16; w++) begin
            do_access("init", 1'b1, 2'b10, 1'b0, BASE + 32'(4 * w), 32'h0, rd, er);
        end
        do_access("init_top", 1'b1, 2'b10, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, rd, er);

        // 1: word store then word load
        do_access("t1_st", 1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF, rd, er);
        do_access("t1_ld", 1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, rd, er);
        check_val("t1_const", rd, 32'hDEADBEEF);

        // 2: byte stores, word and byte loads
        do_access("t2_sb0", 1'b1, 2'b00, 1'b0, 32'h10010009, 32'h0000007F, rd, er);
        do_access("t2_sb1", 1'b1, 2'b00, 1'b0, 32'h1001000A, 32'hFFFFFF80, rd, er);
        do_access("t2_lw", 1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0, rd, er);
        check_val("t2_word_const", rd, 32'h00807F00);
        do_access("t2_lb", 1'b0, 2'b00, 1'b0, 32'h1001000A, 32'h0, rd, er);
        check_val("t2_lb_const", rd, 32'hFFFFFF80);
        do_access("t2_lbu", 1'b0, 2'b00, 1'b1, 32'h1001000A, 32'h0, rd, er);
        check_val("t2_lbu_const", rd, 32'h00000080);

        // 3: half loads from the upper half of 0xDEADBEEF
        do_access("t3_lh", 1'b0, 2'b01, 1'b0, 32'h10010006, 32'h0, rd, er);
        check_val("t3_lh_const", rd, 32'hFFFFDEAD);
        do_access("t3_lhu", 1'b0, 2'b01, 1'b1, 32'h10010006, 32'h0, rd, er);
        check_val("t3_lhu_const", rd, 32'h0000DEAD);

        // 4: out-of-range accesses below and just above the window
        do_access("t4_lo_st", 1'b1, 2'b10, 1'b0, 32'h1000FFFC, 32'hA5A5A5A5, rd, er);
        check_val("t4_lo_err", 32'(er), 32'd1);
        do_access("t4_lo_ld", 1'b0, 2'b10, 1'b0, 32'h1000FFFC, 32'h0, rd, er);
        check_val("t4_lo_rd", rd, 32'h0);
        do_access("t4_hi_st", 1'b1, 2'b10, 1'b0, BASE + 32'(4 * DEPTH), 32'h5A5A5A5A, rd, er);
        check_val("t4_hi_err", 32'(er), 32'd1);
        do_access("t4_n0", 1'b0, 2'b10, 1'b0, BASE, 32'h0, rd, er);
        check_val("t4_n0_const", rd, 32'h0);
        do_access("t4_ntop", 1'b0, 2'b10, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, rd, er);
        check_val("t4_ntop_const", rd, 32'h0);

        // 5: misaligned word load
        do_access("t5_st", 1'b1, 2'b10, 1'b0, BASE, 32'h12345678, rd, er);
        do_access("t5_ld", 1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
        check_val("t5_rd_const", rd, 32'h0);
        check_val("t5_err_const", 32'(er), 32'd1);
`else
        check_val("t5_rd_const", rd, 32'h12345678);
        check_val("t5_err_const", 32'(er), 32'd0);
`endif

        // 6a: reset while waiting for load data
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10010004;
        bus.req_valid    = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset         = 1'b0;
        #1;
        check_val("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("t6_rst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check_val("t6_rst_valid2", 32'(bus.rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_val("t6_rel_ready", 32'(bus.req_ready), 32'd1);
        check_val("t6_rel_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("t6_rel_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        check_val("t6_rel_valid2", 32'(bus.rsp_valid), 32'd0);

        // 6b: back-to-back requests with req_valid held high
        acc    = 0;
        pulses = 0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = BASE;
        bus.req_valid    = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus.req_ready) acc++;
            if (bus.rsp_valid) pulses++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.rsp_valid) pulses++;
            @(negedge clk);
        end
        model_access(1'b0, 2'b10, 1'b0, BASE, 32'h0, exp_rd, exp_err);
        check_val("b2b_accepts", 32'(acc), 32'd4);
        check_val("b2b_pulses", 32'(pulses), 32'(acc));
        check_val("b2b_rdata", bus.rsp_rdata, exp_rd);

        // Random traffic, mostly inside the first 64 bytes
        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            int unsigned pick;
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
                a = BASE - 32'($urandom_range(1, 16));
            end else if (pick == 1) begin
                a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
            end else begin
                a = BASE + 32'($urandom_range(0, 63));
            end
            do_access("rnd", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
